dec8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 3-to-8 enabled decoder among eight requesters. It selects one requester and drives the decoder's 3-bit select and enable, producing a one-hot grant. The grant is held until the requester releases it or a hold limit expires. It sits directly in front of the decoder and is the only block that drives the decoder's select and enable inputs.

---
 rtl/dec8_rr_arbiter.sv | 107 ++++++++++
 tb/tb_dec8_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dec8_rr_arbiter.sv
// Round-robin arbiter owning the select/enable of a 3-to-8 decoder; one-hot grant on Y.
// One cycle request-to-grant, grant held until DONE, withdrawal or the MAX_HOLD limit.
module dec8_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] REQ,
   input  logic       DONE,
   output logic [2:0] A,
   output logic       EN,
   output logic [7:0] Y,
   output logic       TOUT
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         HOLD_ON  = (MAX_HOLD != 0);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] ptr;
   logic [2:0] ptr_nxt;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;
   logic [2:0] a_nxt;
   logic       en_nxt;
   logic       tout_nxt;
   logic [2:0] pick;
   logic       hold_hit;
   logic       withdrawn;
   logic       release_now;

   // Scan from furthest to nearest so the nearest set bit at or after ptr wins.
   always_comb begin
      pick = ptr;
      for (int k = 7; k >= 0; k--) begin
         if (REQ[ptr + 3'(k)]) begin
            pick = ptr + 3'(k);
         end
      end
   end

   assign hold_hit    = HOLD_ON && (cnt == HOLD_LIM);
   assign withdrawn   = !REQ[A];
   assign release_now = DONE || withdrawn || hold_hit;

   always_comb begin
      state_nxt = state;
      a_nxt     = A;
      en_nxt    = EN;
      tout_nxt  = 1'b0;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (|REQ) begin
               a_nxt     = pick;
               en_nxt    = 1'b1;
               cnt_nxt   = 8'd1;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               en_nxt    = 1'b0;
               state_nxt = IDLE;
               ptr_nxt   = A + 3'd1;
               cnt_nxt   = 8'd0;
               // A timeout is only flagged when the limit was the sole reason.
               tout_nxt  = hold_hit && !DONE && !withdrawn;
            end else if (cnt != 8'hFF) begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         A     <= 3'd0;
         EN    <= 1'b0;
         TOUT  <= 1'b0;
         ptr   <= 3'd0;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         A     <= a_nxt;
         EN    <= en_nxt;
         TOUT  <= tout_nxt;
         ptr   <= ptr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign Y = EN ? (8'b1 << A) : 8'h00;

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// Directed bench: main instance with MAX_HOLD=3, plus MAX_HOLD=1 and MAX_HOLD=0 instances on shared inputs.
module tb_dec8_rr_arbiter;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       done;
      logic [2:0] a;
      logic       en;
      logic       tout;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;

   logic [2:0] a3, a1, a0;
   logic       en3, en1, en0;
   logic [7:0] y3, y1, y0;
   logic       tout3, tout1, tout0;

   int total;
   int bad;

   vec_t tbl[$];

   dec8_rr_arbiter #(.MAX_HOLD(3)) u_dut (
      .clk(clk), .rst(rst), .REQ(req), .DONE(done),
      .A(a3), .EN(en3), .Y(y3), .TOUT(tout3)
   );

   dec8_rr_arbiter #(.MAX_HOLD(1)) u_one (
      .clk(clk), .rst(rst), .REQ(req), .DONE(done),
      .A(a1), .EN(en1), .Y(y1), .TOUT(tout1)
   );

   dec8_rr_arbiter #(.MAX_HOLD(0)) u_nolim (
      .clk(clk), .rst(rst), .REQ(req), .DONE(done),
      .A(a0), .EN(en0), .Y(y0), .TOUT(tout0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic [7:0] q, input logic d,
                               input logic [2:0] ea, input logic ee, input logic et);
      vec_t v;
      v.rst  = r;
      v.req  = q;
      v.done = d;
      v.a    = ea;
      v.en   = ee;
      v.tout = et;
      tbl.push_back(v);
   endfunction

   task automatic step(input logic r, input logic [7:0] q, input logic d);
      rst  = r;
      req  = q;
      done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_y;
      int         nolim_bad;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 8'h00;
      done  = 1'b0;

      // reset, then single request and DONE release
      add(1, 8'h00, 0, 3'd0, 0, 0);
      add(1, 8'h00, 0, 3'd0, 0, 0);
      add(0, 8'h10, 0, 3'd4, 1, 0);
      add(0, 8'h10, 1, 3'd4, 0, 0);
      add(0, 8'h00, 0, 3'd4, 0, 0);
      // rotation from a fresh pointer: 0..7,0 with one idle cycle between grants
      add(1, 8'h00, 0, 3'd0, 0, 0);
      for (int k = 0; k < 9; k++) begin
         add(0, 8'hFF, 1, 3'(k), 1, 0);
         add(0, 8'hFF, 1, 3'(k), 0, 0);
      end
      // pointer now 1: grant 6, then wrap 7 -> 0
      add(0, 8'h40, 0, 3'd6, 1, 0);
      add(0, 8'h40, 1, 3'd6, 0, 0);
      add(0, 8'h81, 0, 3'd7, 1, 0);
      add(0, 8'h81, 1, 3'd7, 0, 0);
      add(0, 8'h81, 0, 3'd0, 1, 0);
      add(0, 8'h81, 1, 3'd0, 0, 0);
      // hold limit 3: three grant cycles, timeout pulse, re-grant
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 0, 1);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      // DONE coinciding with the limit suppresses TOUT
      add(0, 8'h04, 1, 3'd2, 0, 0);
      // withdrawal mid-grant
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h00, 0, 3'd2, 0, 0);
      // withdrawal coinciding with the limit suppresses TOUT
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h04, 0, 3'd2, 1, 0);
      add(0, 8'h00, 0, 3'd2, 0, 0);
      // DONE while idle is ignored
      add(0, 8'h00, 1, 3'd2, 0, 0);
      // other REQ bits toggling during a grant do not move A
      add(0, 8'h08, 0, 3'd3, 1, 0);
      add(0, 8'h0F, 0, 3'd3, 1, 0);
      add(0, 8'h08, 0, 3'd3, 1, 0);
      add(0, 8'h08, 0, 3'd3, 0, 1);
      // reset mid-grant clears pointer
      add(0, 8'h20, 0, 3'd5, 1, 0);
      add(1, 8'h20, 0, 3'd0, 0, 0);
      add(0, 8'h21, 0, 3'd0, 1, 0);
      add(0, 8'h21, 1, 3'd0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].done);
         exp_y = tbl[i].en ? (8'h01 << tbl[i].a) : 8'h00;
         check($sformatf("v%0d_A", i), 32'(a3), 32'(tbl[i].a));
         check($sformatf("v%0d_EN", i), 32'(en3), 32'(tbl[i].en));
         check($sformatf("v%0d_Y", i), 32'(y3), 32'(exp_y));
         check($sformatf("v%0d_TOUT", i), 32'(tout3), 32'(tbl[i].tout));
      end

      // MAX_HOLD=1: every grant lasts exactly one cycle, each ending in a timeout
      step(1, 8'h00, 0);
      check("one_rst_EN", 32'(en1), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(0, 8'h04, 0);
         check($sformatf("one_g%0d_EN", k), 32'(en1), 32'd1);
         check($sformatf("one_g%0d_Y", k), 32'(y1), 32'h04);
         step(0, 8'h04, 0);
         check($sformatf("one_r%0d_EN", k), 32'(en1), 32'd0);
         check($sformatf("one_r%0d_TOUT", k), 32'(tout1), 32'd1);
      end

      // MAX_HOLD=0: a long hold is never revoked (counter saturates past 255)
      step(1, 8'h00, 0);
      step(0, 8'h04, 0);
      check("nolim_A", 32'(a0), 32'd2);
      check("nolim_EN", 32'(en0), 32'd1);
      nolim_bad = 0;
      for (int k = 0; k < 1000; k++) begin
         step(0, 8'h04, 0);
         if (en0 !== 1'b1 || tout0 !== 1'b0 || y0 !== 8'h04) nolim_bad++;
      end
      check("nolim_hold_errors", 32'(nolim_bad), 32'd0);
      step(0, 8'h00, 0);
      check("nolim_drop_EN", 32'(en0), 32'd0);
      check("nolim_drop_TOUT", 32'(tout0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
